// File: rtl/muldiv_if.sv
// Handshake and result bundle between the CPU control unit and the MUL/DIV engine.
// The control unit is the master and the engine is the slave.
interface muldiv_if #(parameter int WIDTH = 4);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hold;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             z_f;
  logic             s_f;
  logic             dz_err;

  modport master (output start, op, a, b,
                  input  hold, busy, done, hi, lo, z_f, s_f, dz_err);
  modport slave  (input  start, op, a, b,
                  output hold, busy, done, hi, lo, z_f, s_f, dz_err);
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider for the 4-bit CPU.
// Stalls the ring counter through hold while it iterates; results land on entry to DONE.
module muldiv_seq #(parameter int WIDTH = 4) (
  input  logic     clk,
  input  logic     clr,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic               op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;

  // One iteration. The shifted remainder is WIDTH+1 bits wide so the bit leaving
  // the top of rem is kept for the trial subtraction.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    trial   = {1'b0, rem_sh} - {2'b00, b_q};
    if (!op_q)
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (!trial[WIDTH+1])
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  assign bus.hold = ((state == IDLE) && bus.start) || (state == CALC);
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      count      <= '0;
      bus.done   <= 1'b0;
      bus.hi     <= '0;
      bus.lo     <= '0;
      bus.z_f    <= 1'b0;
      bus.s_f    <= 1'b0;
      bus.dz_err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          op_q  <= bus.op;
          a_q   <= bus.a;
          b_q   <= bus.b;
          count <= CW'(WIDTH);
          if (bus.op && (bus.b == '0)) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.hi     <= bus.a;
            bus.lo     <= '1;
            bus.z_f    <= 1'b0;
            bus.s_f    <= bus.a[WIDTH-1];
            bus.dz_err <= 1'b1;
          end else begin
            state <= CALC;
            // MUL keeps the multiplier in the low half; DIV starts with rem=0, quo=a.
            acc   <= bus.op ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{1'b0}}, bus.b};
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.hi     <= acc_nxt[2*WIDTH-1:WIDTH];
            bus.lo     <= acc_nxt[WIDTH-1:0];
            bus.z_f    <= (acc_nxt == '0);
            bus.s_f    <= acc_nxt[2*WIDTH-1];
            bus.dz_err <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Random and directed checks of muldiv_seq against plain integer multiply/divide.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  muldiv_if #(.WIDTH(4)) bus();
  muldiv_seq #(.WIDTH(4)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs_word();
    return int'({bus.hold, bus.busy, bus.done, bus.hi, bus.lo, bus.z_f, bus.s_f, bus.dz_err});
  endfunction

  task automatic ref_model(input logic o, input int x, input int y,
                           output int hi, output int lo, output int dz);
    int p;
    if (!o) begin
      p = x * y; hi = p / 16; lo = p % 16; dz = 0;
    end else if (y == 0) begin
      hi = x; lo = 15; dz = 1;
    end else begin
      hi = x % y; lo = x / y; dz = 0;
    end
  endtask

  task automatic check_result(input logic o, input int x, input int y);
    int hi, lo, dz;
    ref_model(o, x, y, hi, lo, dz);
    chk("hi", int'(bus.hi), hi);
    chk("lo", int'(bus.lo), lo);
    chk("z_f", int'(bus.z_f), int'(hi == 0 && lo == 0));
    chk("s_f", int'(bus.s_f), hi / 8);
    chk("dz_err", int'(bus.dz_err), dz);
  endtask

  // Issue one op at a negedge and follow it cycle by cycle until done.
  task automatic do_op(input logic o, input int x, input int y);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = 4'(x); bus.b = 4'(y);
    #1 chk("hold_start", int'(bus.hold), 1);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 12) begin
      chk("hold_calc", int'(bus.hold), 1);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, (o && y == 0) ? 1 : 5);
    chk("hold_done", int'(bus.hold), 0);
    chk("busy_done", int'(bus.busy), 1);
    check_result(o, x, y);
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 0);
    chk("busy_idle", int'(bus.busy), 0);
    check_result(o, x, y);
  endtask

  initial begin
    int d1, d2, nd;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    #2 chk("reset_outs", outs_word(), 0);
    @(negedge clk); clr = 1'b1;

    do_op(1'b0, 7, 9);
    do_op(1'b1, 13, 4);
    do_op(1'b1, 9, 0);
    do_op(1'b0, 15, 15);
    do_op(1'b0, 0, 5);
    do_op(1'b1, 0, 0);
    do_op(1'b1, 15, 1);
    do_op(1'b1, 3, 15);

    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) @(negedge clk);
      do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            (i % 8 == 0) ? 0 : int'($urandom_range(0, 15)));
    end

    // start held for 12 cycles: accepted at cycle 0 and again at cycle 6
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd3; bus.b = 4'd5;
    d1 = 0; d2 = 0; nd = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 12) bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (nd == 1) d1 = c; else d2 = c;
      end
    end
    chk("held_done_count", nd, 2);
    chk("held_first_done", d1, 5);
    chk("held_second_done", d2, 11);
    #1 chk("held_busy_after", int'(bus.busy), 0);
    check_result(1'b0, 3, 5);

    // async clear in the second CALC cycle aborts the op
    do_op(1'b0, 15, 15);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd7; bus.b = 4'd9;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1 chk("clr_outs", outs_word(), 0);
    @(negedge clk); clr = 1'b1;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    chk("clr_no_done", nd, 0);
    do_op(1'b0, 7, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
